// File: rtl/uproc_pkg.sv
// Shared micro-processor definitions: default widths, control opcodes and the PC type.
package uproc_pkg;

  localparam int DEF_PC_W  = 12;
  localparam int DEF_DEPTH = 8;

  localparam logic [3:0] OP_CALL = 4'b1110;
  localparam logic [3:0] OP_RET0 = 4'b1100;
  localparam logic [3:0] OP_RET1 = 4'b1101;

  typedef logic [DEF_PC_W-1:0] pc_t;

endpackage

// File: rtl/stack_regfile.sv
// Return-address storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset; validity is tracked by the stack's count.
module stack_regfile #(
  parameter int PC_W  = 12,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [PC_W-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [PC_W-1:0] rdata
);

  logic [PC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uproc_call_stack.sv
// Return-address stack for CALL/RET: pointer, count and sticky error flags,
// plus the zero-latency next-PC mux (stack top vs. jump target).
module uproc_call_stack
  import uproc_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            stack_up,
  input  logic            stack_down,
  input  logic            c_stack,
  input  logic [PC_W-1:0] ret_addr_in,
  input  logic [PC_W-1:0] jump_target,
  output logic [PC_W-1:0] pc_jump,
  output logic [CW-1:0]   count,
  output logic            empty,
  output logic            full,
  output logic            overflow,
  output logic            underflow
);

  logic [AW-1:0]   sp, sp_d, sp_m1, sp_p1;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [PC_W-1:0] top;
  logic            do_push, do_pop, do_both;
  logic            is_empty, is_full;

  assign sp_m1    = sp - AW'(1);
  assign sp_p1    = sp + AW'(1);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  assign do_push = en & stack_up & ~stack_down;
  assign do_pop  = en & stack_down & ~stack_up;
  assign do_both = en & stack_up & stack_down;

  always_comb begin
    we      = 1'b0;
    waddr   = sp;
    sp_d    = sp;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (do_push) begin
      we   = 1'b1;
      sp_d = sp_p1;
      // When full the write lands on the oldest entry; count saturates.
      if (is_full) ovf_d = 1'b1;
      else         count_d = count_q + CW'(1);
    end else if (do_pop) begin
      if (is_empty) begin
        unf_d = 1'b1;
      end else begin
        sp_d    = sp_m1;
        count_d = count_q - CW'(1);
      end
    end else if (do_both) begin
      we = 1'b1;
      if (is_empty) begin
        sp_d    = sp_p1;
        count_d = count_q + CW'(1);
        unf_d   = 1'b1;
      end else begin
        waddr = sp_m1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp      <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp      <= sp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  stack_regfile #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (ret_addr_in),
    .raddr (sp_m1),
    .rdata (top)
  );

  assign pc_jump   = !c_stack ? jump_target : (is_empty ? '0 : top);
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_uproc_call_stack.sv
// Self-checking bench for uproc_call_stack against a queue-based LIFO model.
module tb_uproc_call_stack;
  import uproc_pkg::*;

  localparam int DEPTH = DEF_DEPTH;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0, stack_up = 1'b0, stack_down = 1'b0, c_stack = 1'b0;
  pc_t           ret_addr_in = '0, jump_target = '0;
  pc_t           pc_jump;
  logic [CW-1:0] count;
  logic          empty, full, overflow, underflow;

  int checks = 0;
  int failures = 0;

  pc_t q[$];
  bit  m_ovf, m_unf;

  uproc_call_stack #(.PC_W(DEF_PC_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .stack_up    (stack_up),
    .stack_down  (stack_down),
    .c_stack     (c_stack),
    .ret_addr_in (ret_addr_in),
    .jump_target (jump_target),
    .pc_jump     (pc_jump),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  function automatic pc_t exp_pc();
    if (!c_stack) return jump_target;
    if (q.size() == 0) return '0;
    return q[q.size()-1];
  endfunction

  // LIFO semantics stated directly: bounded history, oldest dropped on overflow.
  task automatic model_update();
    if (!rst_n || !en) return;
    if (stack_up && !stack_down) begin
      if (q.size() == DEPTH) begin
        void'(q.pop_front());
        m_ovf = 1;
      end
      q.push_back(ret_addr_in);
    end else if (stack_down && !stack_up) begin
      if (q.size() > 0) void'(q.pop_back());
      else m_unf = 1;
    end else if (stack_down && stack_up) begin
      if (q.size() > 0) q[q.size()-1] = ret_addr_in;
      else begin
        q.push_back(ret_addr_in);
        m_unf = 1;
      end
    end
  endtask

  task automatic set_in(input logic e, input logic u, input logic d, input logic c,
                        input pc_t r, input pc_t j);
    @(negedge clk);
    en = e; stack_up = u; stack_down = d; c_stack = c; ret_addr_in = r; jump_target = j;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 0; stack_up = 0; stack_down = 0;
    rst_n = 0;
    #2;
    q.delete(); m_ovf = 0; m_unf = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    en = 0; c_stack = 1; jump_target = 12'h3A5;
    #2;
    checks++; if (pc_jump !== 12'h000) begin failures++; $display("FAIL reset_pc_c1 got=%0h exp=0", pc_jump); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    checks++; if (count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL reset_flags got=%0b%0b exp=00", overflow, underflow); end
    c_stack = 0;
    #1;
    checks++; if (pc_jump !== 12'h3A5) begin failures++; $display("FAIL reset_pc_c0 got=%0h exp=3a5", pc_jump); end
    @(negedge clk);
    rst_n = 1;
    q.delete(); m_ovf = 0; m_unf = 0;
  endtask

  task automatic test_lifo();
    pc_t vals[3] = '{12'h010, 12'h020, 12'h030};
    pc_t exp_pop[3] = '{12'h030, 12'h020, 12'h010};
    foreach (vals[i]) begin
      set_in(1, 1, 0, 0, vals[i], 12'h000);
      tick();
    end
    checks++; if (count !== CW'(3)) begin failures++; $display("FAIL lifo_count got=%0d exp=3", count); end
    foreach (exp_pop[i]) begin
      set_in(1, 0, 1, 1, 12'h000, 12'h7FF);
      checks++; if (pc_jump !== exp_pop[i]) begin failures++; $display("FAIL lifo_pop%0d got=%0h exp=%0h", i, pc_jump, exp_pop[i]); end
      tick();
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL lifo_empty got=%0b exp=1", empty); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL lifo_unf got=%0b exp=0", underflow); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      set_in(1, 1, 0, 0, pc_t'(12'h100 + i), 12'h000);
      tick();
      if (i == 8) begin
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL ovf_full8 got=%0b exp=1", full); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%0b exp=0", overflow); end
      end
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
    checks++; if (count !== CW'(8)) begin failures++; $display("FAIL ovf_count got=%0d exp=8", count); end
    for (int i = 9; i >= 2; i--) begin
      set_in(1, 0, 1, 1, 12'h000, 12'h000);
      checks++; if (pc_jump !== pc_t'(12'h100 + i)) begin failures++; $display("FAIL ovf_pop got=%0h exp=%0h", pc_jump, 12'h100 + i); end
      tick();
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ovf_drained got=%0b exp=1", empty); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
  endtask

  task automatic test_underflow();
    do_reset();
    set_in(1, 0, 1, 1, 12'h000, 12'h000);
    tick();
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL unf_flag got=%0b exp=1", underflow); end
    checks++; if (count !== '0) begin failures++; $display("FAIL unf_count got=%0d exp=0", count); end
    set_in(1, 1, 0, 0, 12'h0AA, 12'h000);
    tick();
    set_in(1, 0, 1, 1, 12'h000, 12'h000);
    checks++; if (pc_jump !== 12'h0AA) begin failures++; $display("FAIL unf_pop got=%0h exp=0aa", pc_jump); end
    tick();
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL unf_sticky got=%0b exp=1", underflow); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_in(1, 1, 0, 0, 12'h011, 12'h000);
    tick();
    set_in(1, 1, 1, 1, 12'h022, 12'h000);
    checks++; if (pc_jump !== 12'h011) begin failures++; $display("FAIL both_oldtop got=%0h exp=011", pc_jump); end
    tick();
    checks++; if (count !== CW'(1)) begin failures++; $display("FAIL both_count got=%0d exp=1", count); end
    set_in(0, 1, 0, 1, 12'h033, 12'h000);
    tick();
    checks++; if (count !== CW'(1)) begin failures++; $display("FAIL stall_count got=%0d exp=1", count); end
    set_in(1, 0, 1, 1, 12'h000, 12'h000);
    checks++; if (pc_jump !== 12'h022) begin failures++; $display("FAIL both_pop got=%0h exp=022", pc_jump); end
    tick();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL both_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_in(1, 1, 0, 0, 12'h055, 12'h000);
    tick();
    set_in(1, 1, 0, 0, 12'h066, 12'h000);
    tick();
    @(negedge clk);
    en = 0; stack_up = 0; stack_down = 0; c_stack = 1;
    #1 rst_n = 0;
    #1;
    q.delete(); m_ovf = 0; m_unf = 0;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL arst_empty got=%0b exp=1", empty); end
    checks++; if (count !== '0) begin failures++; $display("FAIL arst_count got=%0d exp=0", count); end
    #1 rst_n = 1;
    set_in(1, 0, 1, 1, 12'h000, 12'h123);
    checks++; if (pc_jump !== 12'h000) begin failures++; $display("FAIL arst_pc got=%0h exp=0", pc_jump); end
    tick();
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL arst_unf got=%0b exp=1", underflow); end
  endtask

  task automatic test_random();
    int op;
    pc_t exp;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      set_in(logic'($urandom_range(0, 7) != 0),
             logic'(op <= 3 || op == 8),
             logic'((op >= 4 && op <= 7) || op == 8),
             logic'($urandom_range(0, 1)),
             pc_t'($urandom), pc_t'($urandom));
      exp = exp_pc();
      checks++; if (pc_jump !== exp) begin failures++; $display("FAIL rnd_pc n=%0d got=%0h exp=%0h", n, pc_jump, exp); end
      tick();
      checks++;
      if (count !== CW'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH) ||
          overflow !== m_ovf || underflow !== m_unf) begin
        failures++;
        $display("FAIL rnd_state n=%0d got cnt=%0d e=%0b f=%0b o=%0b u=%0b exp cnt=%0d o=%0b u=%0b",
                 n, count, empty, full, overflow, underflow, q.size(), m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lifo();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
